// File: rtl/pulse_irq_ctrl.sv
// Pulse-to-interrupt controller: counts button events and raises a level
// IRQ per pending event, with a fixed low gap after each acknowledge.
module pulse_irq_ctrl #(
    parameter int CNT_W      = 8,
    parameter int GAP_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             btn_pls_in,
    input  logic             irq_en,
    input  logic             irq_ack,
    input  logic             ovf_clr,
    output logic             irq_out,
    output logic [CNT_W-1:0] pend_cnt,
    output logic             ovf
);

    localparam int GAP_W = $clog2(GAP_CYCLES + 1);

    if (GAP_CYCLES == 0) begin : g_bad_gap
        $error("pulse_irq_ctrl: GAP_CYCLES must be at least 1");
    end

    typedef enum logic [1:0] {
        IDLE,
        ASSERT,
        GAP
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic               ovf_q, ovf_d;
    logic               irq_q;
    logic               ack_ok;
    logic               at_max;

    assign ack_ok = irq_ack && (state_q == ASSERT);
    assign at_max = (cnt_q == {CNT_W{1'b1}});

    // A pulse and a valid ack in the same cycle cancel out.
    always_comb begin
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (btn_pls_in && !ack_ok) begin
            if (!at_max) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (ack_ok && !btn_pls_in && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
        if (btn_pls_in && !ack_ok && at_max) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        unique case (state_q)
            IDLE: begin
                if ((cnt_q != '0) && irq_en) begin
                    state_d = ASSERT;
                end
            end
            ASSERT: begin
                if (irq_ack) begin
                    state_d = GAP;
                    gap_d   = GAP_W'(GAP_CYCLES - 1);
                end else if (!irq_en) begin
                    state_d = IDLE;
                end
            end
            GAP: begin
                if (gap_q == '0) begin
                    state_d = ((cnt_q != '0) && irq_en) ? ASSERT : IDLE;
                end else begin
                    gap_d = gap_q - GAP_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                gap_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            gap_q   <= '0;
            ovf_q   <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
            ovf_q   <= ovf_d;
            irq_q   <= (state_d == ASSERT);
        end
    end

    assign irq_out  = irq_q;
    assign pend_cnt = cnt_q;
    assign ovf      = ovf_q;

endmodule

// File: doc/pulse_irq_ctrl.md
PULSE_IRQ_CTRL -- requirements
Module: pulse_irq_ctrl

Interface
REQ-001 The block SHALL have parameter CNT_W, default 8: width of the pending-event counter.
REQ-002 The block SHALL have parameter GAP_CYCLES, default 4: number of cycles irq_out is held low between consecutive assertions.
REQ-003 Port clk, input, 1: the single clock; all state SHALL be updated on its rising edge.
REQ-004 Port rst_n, input, 1: reset, asynchronous and active-low.
REQ-005 Port btn_pls_in, input, 1: single-cycle event pulse from the debounced button; each sampled-high cycle is one event.
REQ-006 Port irq_en, input, 1: interrupt enable; level.
REQ-007 Port irq_ack, input, 1: software acknowledge; single-cycle pulse.
REQ-008 Port ovf_clr, input, 1: clears the overflow flag; single-cycle pulse.
REQ-009 Port irq_out, output, 1: level interrupt request to the processor, Moore output.
REQ-010 Port pend_cnt, output, CNT_W: current pending-event count.
REQ-011 Port ovf, output, 1: sticky flag, set when an event is lost to saturation.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, ASSERT and GAP.
REQ-013 irq_out SHALL be 1 only in ASSERT and SHALL be driven directly from a register.
REQ-014 Pending counter, btn_pls_in=1 and no decrement: the counter SHALL increment by 1, saturating at 2^CNT_W-1.
REQ-015 Decrement: the counter SHALL decrement by 1 only when irq_ack=1 while the state is ASSERT.
REQ-016 Simultaneous increment and decrement in the same cycle: the counter SHALL be unchanged.
REQ-017 The counter SHALL never underflow.
REQ-018 An irq_ack received outside ASSERT SHALL be ignored, with no counter or state change.
REQ-019 ovf SHALL be set on a cycle where btn_pls_in=1, pend_cnt=2^CNT_W-1 and no valid ack occurs.
REQ-020 ovf SHALL clear on ovf_clr=1.
REQ-021 If ovf_clr and an overflow event occur in the same cycle, set SHALL win.
REQ-022 IDLE -> ASSERT when the registered pend_cnt!=0 and irq_en=1; otherwise the FSM SHALL remain in IDLE.
REQ-023 Latency: a pulse sampled at edge N in IDLE with pend_cnt=0 and irq_en=1 SHALL give pend_cnt=1 after edge N and irq_out=1 after edge N+1.
REQ-024 ASSERT -> GAP on irq_ack=1, loading the gap counter with GAP_CYCLES-1.
REQ-025 ASSERT -> IDLE on irq_en=0 with irq_ack=0; pend_cnt SHALL be retained, not cleared.
REQ-026 ASSERT with irq_en=0 and irq_ack=1 in the same cycle: ack SHALL take priority, with decrement and transition to GAP.
REQ-027 GAP SHALL hold irq_out=0 for exactly GAP_CYCLES cycles, decrementing the gap counter; irq_en changes and pulses during GAP SHALL NOT shorten it.
REQ-028 GAP exit: on the last GAP cycle, -> ASSERT if pend_cnt!=0 and irq_en=1, else -> IDLE.
REQ-029 Pulses arriving during GAP SHALL still be counted.
REQ-030 GAP_CYCLES=0 is illegal; the block SHALL flag it with an elaboration-time check.
REQ-031 The gap counter width SHALL be $clog2(GAP_CYCLES+1).
REQ-032 All counters SHALL be unsigned; no arithmetic SHALL wrap.

Reset
REQ-033 While rst_n=0, asynchronously: state=IDLE, irq_out=0, pend_cnt=0, ovf=0, gap counter=0.
REQ-034 Assertion of rst_n mid-operation, in any state, SHALL discard all pending events.
REQ-035 After rst_n deasserts, the first state update SHALL occur on the next rising clk edge.
REQ-036 A btn_pls_in high on the first edge after reset release SHALL be counted.

Verification
REQ-037 Single event: irq_en=1, one pulse -> pend_cnt=1 after 1 edge, irq_out=1 after 2 edges; ack -> pend_cnt=0, irq_out low, FSM stays IDLE after GAP.
REQ-038 Back-to-back events: 3 pulses, then ack 3 times, each ack as soon as irq_out=1 -> pend_cnt 3,2,1,0; irq_out low exactly 4 cycles between each assertion; final state IDLE.
REQ-039 Simultaneous pulse and ack in ASSERT with pend_cnt=2 -> pend_cnt stays 2, FSM -> GAP, then re-asserts after 4 cycles.
REQ-040 Saturation with CNT_W=2: 5 pulses, irq_en=0 -> pend_cnt=3, ovf=1, irq_out=0; ovf_clr -> ovf=0; irq_en=1 -> irq_out=1 after 1 edge.
REQ-041 Spurious or disabled operation: ack while in IDLE -> no change; irq_en dropped in ASSERT with pend_cnt=1 -> irq_out=0 next edge and pend_cnt=1; re-enable -> irq_out=1.
REQ-042 Reset mid-GAP with pend_cnt=2 -> irq_out=0, pend_cnt=0, ovf=0 immediately; no assertion after release without new pulses.
